// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the combinational ROM address,
// predecodes unconditional jumps and loads the IF/ID register for decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  JUMP_OPCODE = 6'b010010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic        is_jump;
  logic [31:0] jump_pc;
  logic [31:0] seq_pc;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsbs;

  assign rom_addr = pc;

  always_comb begin
    is_jump      = (rom_inst[31:26] == JUMP_OPCODE);
    // Jump field is a word index within the current 256 MB region.
    jump_pc      = {pc[31:28], rom_inst[25:0], 2'b00};
    seq_pc       = pc + 32'd4;
    redirect_tgt = {redirect_pc[31:2], 2'b00};
  end

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      id_inst     <= 32'd0;
      id_pc       <= 32'd0;
      id_valid    <= 1'b0;
      fetch_count <= 32'd0;
    end else if (redirect) begin
      // Redirect beats stall: the in-flight word is dropped as a bubble.
      pc       <= redirect_tgt;
      id_inst  <= 32'd0;
      id_pc    <= 32'd0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= is_jump ? jump_pc : seq_pc;
      id_inst     <= rom_inst;
      id_pc       <= pc;
      id_valid    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed stimulus pushes per-edge expectations,
// a negedge monitor pops and compares them. A second instance covers PC wrap.
module tb_inst_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: RESET_PC = 0
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, rom_addr, rom_inst, id_inst, id_pc, fetch_count;
  logic        id_valid;

  // instance B: RESET_PC = 0xFFFFFFFC
  logic        rst_w, stall_w, redirect_w;
  logic [31:0] redirect_pc_w, rom_addr_w, rom_inst_w, id_inst_w, id_pc_w, fetch_count_w;
  logic        id_valid_w;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    case (a)
      32'h00: rom_fn = 32'h0000_0000;
      32'h04: rom_fn = 32'h0420_1422;
      32'h08: rom_fn = 32'h2400_3066;
      32'h18: rom_fn = 32'h4800_0008;
      32'h20: rom_fn = 32'h1400_0464;
      default: rom_fn = {16'h2000, a[15:0]};
    endcase
  endfunction

  assign rom_inst   = rom_fn(rom_addr);
  assign rom_inst_w = rom_fn(rom_addr_w);

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_inst(rom_inst), .id_inst(id_inst), .id_pc(id_pc),
    .id_valid(id_valid), .fetch_count(fetch_count)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .stall(stall_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .rom_addr(rom_addr_w), .rom_inst(rom_inst_w), .id_inst(id_inst_w), .id_pc(id_pc_w),
    .id_valid(id_valid_w), .fetch_count(fetch_count_w)
  );

  typedef struct {
    int          which;
    int          cyc;
    string       name;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int which, input string name, input int at,
                           input logic [31:0] addr, input logic [31:0] inst,
                           input logic [31:0] pc, input logic valid, input logic [31:0] cnt);
    exp_t e;
    e.which = which; e.cyc = at; e.name = name;
    e.addr = addr; e.inst = inst; e.pc = pc; e.valid = valid; e.cnt = cnt;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s.%s actual=%h required=%h (cycle %0d)", name, field, act, req, cyc);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      if (mon_e.cyc < cyc) begin
        chk(mon_e.name, "stale_cycle", cyc, mon_e.cyc);
      end else if (mon_e.which == 0) begin
        chk(mon_e.name, "rom_addr",    rom_addr,         mon_e.addr);
        chk(mon_e.name, "id_inst",     id_inst,          mon_e.inst);
        chk(mon_e.name, "id_pc",       id_pc,            mon_e.pc);
        chk(mon_e.name, "id_valid",    {31'd0, id_valid}, {31'd0, mon_e.valid});
        chk(mon_e.name, "fetch_count", fetch_count,      mon_e.cnt);
      end else begin
        chk(mon_e.name, "rom_addr",    rom_addr_w,         mon_e.addr);
        chk(mon_e.name, "id_inst",     id_inst_w,          mon_e.inst);
        chk(mon_e.name, "id_pc",       id_pc_w,            mon_e.pc);
        chk(mon_e.name, "id_valid",    {31'd0, id_valid_w}, {31'd0, mon_e.valid});
        chk(mon_e.name, "fetch_count", fetch_count_w,      mon_e.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    rst_w = 1'b1; stall_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = 32'd0;

    expect_at(0, "reset",   2, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    expect_at(1, "w_reset", 2, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd0);
    step(); step();
    rst = 1'b0; rst_w = 1'b0;

    expect_at(0, "first",  3, 32'h04, 32'h0000_0000, 32'h00, 1'b1, 32'd1);
    expect_at(1, "w_wrap", 3, 32'h00, 32'h2000_FFFC, 32'hFFFF_FFFC, 1'b1, 32'd1);
    step();
    rst_w = 1'b1; stall_w = 1'b1;

    expect_at(0, "seq1",        4, 32'h08, 32'h0420_1422, 32'h04, 1'b1, 32'd2);
    expect_at(1, "w_rst_stall", 4, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd0);
    step();
    rst_w = 1'b0; stall_w = 1'b0;

    expect_at(0, "seq2",    5, 32'h0C, 32'h2400_3066, 32'h08, 1'b1, 32'd3);
    expect_at(1, "w_after", 5, 32'h00, 32'h2000_FFFC, 32'hFFFF_FFFC, 1'b1, 32'd1);
    step();
    stall = 1'b1;

    expect_at(0, "stall1", 6, 32'h0C, 32'h2400_3066, 32'h08, 1'b1, 32'd3);
    expect_at(0, "stall2", 7, 32'h0C, 32'h2400_3066, 32'h08, 1'b1, 32'd3);
    step(); step();
    stall = 1'b0;

    expect_at(0, "resume",  8, 32'h10, 32'h2000_000C, 32'h0C, 1'b1, 32'd4);
    expect_at(0, "seq3",    9, 32'h14, 32'h2000_0010, 32'h10, 1'b1, 32'd5);
    expect_at(0, "seq4",   10, 32'h18, 32'h2000_0014, 32'h14, 1'b1, 32'd6);
    expect_at(0, "jump",   11, 32'h20, 32'h4800_0008, 32'h18, 1'b1, 32'd7);
    expect_at(0, "jtarget",12, 32'h24, 32'h1400_0464, 32'h20, 1'b1, 32'd8);
    repeat (5) step();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0007;

    expect_at(0, "redir_stall", 13, 32'h04, 32'h0, 32'h0, 1'b0, 32'd8);
    step();
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

    expect_at(0, "redir_target", 14, 32'h08, 32'h0420_1422, 32'h04, 1'b1, 32'd9);
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_001A;

    expect_at(0, "redir_only", 15, 32'h18, 32'h0, 32'h0, 1'b0, 32'd9);
    step();
    redirect = 1'b0; redirect_pc = 32'd0;

    expect_at(0, "redir_jump", 16, 32'h20, 32'h4800_0008, 32'h18, 1'b1, 32'd10);
    step();

    for (int i = 0; i < 10 && sbq.size() > 0; i++) step();
    if (sbq.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch (IF) stage of the pipelined CPU, directly upstream of the combinational instruction ROM. It owns the program counter and drives the ROM byte address. It takes the returned instruction word and registers it, with its PC, into the IF/ID pipeline register for the decode stage. It resolves unconditional jumps at fetch time, accepts redirects from later stages, and honours pipeline stalls. It also keeps a count of delivered instructions.

## Interface
Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset
- JUMP_OPCODE, 6'b010010, value of inst[31:26] that marks an unconditional jump

Ports:
- clk  input  1  the single clock; all state updates on its rising edge
- rst  input  1  reset, synchronous and active-high
- stall  input  1  hazard stall from decode; holds PC, IF/ID and counter
- redirect  input  1  taken branch/exception redirect from a later stage
- redirect_pc  input  32  byte target of redirect; bits [1:0] ignored (forced 0)
- rom_addr  output  32  byte address to ROM `a` port; equals current PC (combinational from PC register)
- rom_inst  input  32  instruction word returned combinationally by ROM for rom_addr
- id_inst  output  32  IF/ID registered instruction
- id_pc  output  32  IF/ID registered byte PC of id_inst
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
- fetch_count  output  32  number of instructions delivered into IF/ID since reset

## Operation
- State: pc[31:0], IF/ID register {id_inst, id_pc, id_valid}, fetch_count[31:0].
- Reset (rst=1 at an edge) sets pc=RESET_PC, id_inst=0, id_pc=0, id_valid=0 and fetch_count=0. Reset overrides every other input.
- Jump predecode is combinational on rom_inst: is_jump = (rom_inst[31:26]==JUMP_OPCODE). jump_pc = {pc[31:28], rom_inst[25:0], 2'b00}, i.e. rom_inst[25:0] is a word index.
- Next-state priority per edge is rst > redirect > stall > jump > sequential:
  - redirect=1: pc = {redirect_pc[31:2],2'b00}. IF/ID is loaded with a bubble (id_inst=0, id_pc=0, id_valid=0). fetch_count is unchanged. The currently fetched word is discarded even if stall=1.
  - stall=1 (no redirect): pc, IF/ID and fetch_count all hold. The jump predecode has no effect.
  - is_jump=1: pc = jump_pc. IF/ID = {rom_inst, pc, 1}. fetch_count+1. The jump itself is delivered to decode as a valid instruction. There is no delay slot and no bubble.
  - Otherwise: pc = pc+4, with modulo-2^32 wrap (0xFFFFFFFC → 0x00000000). IF/ID = {rom_inst, pc, 1}. fetch_count+1.
- fetch_count wraps modulo 2^32.
- The all-zero word is a NOP. It is delivered with id_valid=1 like any other instruction; only redirect and reset generate bubbles.
- rom_addr carries the full PC. Aliasing beyond ROM depth is the ROM's concern.

## Timing
- The ROM is combinational, so fetch latency is 1 cycle: the word at rom_addr is in IF/ID after the next rising edge.
- First cycle after rst deasserts: rom_addr=RESET_PC. At the following edge, id_pc=RESET_PC, id_valid=1 and rom_addr=RESET_PC+4.
- Jump penalty: 0 cycles. Redirect penalty: 1 bubble cycle (id_valid=0), then the target instruction appears the edge after.
- Redirect is sampled in the same cycle it is asserted; the new rom_addr is visible the cycle after that edge.
- stall and redirect asserted together: redirect wins, as above.
- rst asserted mid-stall or mid-redirect: reset values at that edge.

## Test plan
- Reset: hold rst 2 cycles. Required: rom_addr=0, id_inst=0, id_valid=0, fetch_count=0. First edge after release: id_pc=0, id_valid=1, rom_addr=4, fetch_count=1.
- Sequential fetch with ROM words 0x00000000, 0x04201422, 0x24003066. After the 3rd post-reset edge: id_inst=0x24003066, id_pc=0x08, rom_addr=0x0C, fetch_count=3.
- Jump: ROM[0x18]=0x48000008, ROM[0x20]=0x14000464.
  - Edge after fetching 0x18: id_inst=0x48000008, id_pc=0x18, rom_addr=0x20.
  - Next edge: id_inst=0x14000464, id_pc=0x20, rom_addr=0x24.
- Stall: assert stall for 2 cycles with pc=0x0C. Required: rom_addr, id_inst, id_pc, id_valid and fetch_count are all unchanged. Sequential fetch resumes from 0x0C on release.
- Redirect with stall in the same cycle, redirect_pc=0x00000007. Required at that edge: rom_addr=0x04, id_valid=0, id_inst=0, fetch_count unchanged. Next edge: id_pc=0x04, id_valid=1.
- Wrap/reset: with RESET_PC=0xFFFFFFFC, the edge after reset gives rom_addr=0x00000000. Then assert rst while stall=1: the next edge gives rom_addr=0xFFFFFFFC, id_valid=0, fetch_count=0.
